// File: rtl/prog_loader.sv
// Byte-stream program loader: frames host bytes into 16-bit ROM writes and holds the CPU.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module prog_loader #(
   parameter int DEPTH          = 4096,
   parameter int START_ADDR     = 0,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [15:0] wr_addr,
   output logic [15:0] wr_data,
   output logic        wr_en,
   output logic        cpu_hold,
   output logic        done,
   output logic        err
);

   typedef enum logic [3:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
      S_WRITE, S_CSUM, S_DONE, S_ERROR
   } state_t;

   localparam logic [16:0] DEPTH_W = 17'(DEPTH);
   localparam logic [15:0] BASE    = 16'(START_ADDR);

   state_t      state, state_nx;
   logic [15:0] count, len, len_full;
   logic [7:0]  sum, hi;
   logic        take, hdr, timeout;

   assign take     = rx_valid && rx_ready;
   assign hdr      = rx_data == 8'hA5;
   assign len_full = {len[15:8], rx_data};

`ifdef LOADER_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] idle;
   logic        active;

   assign active = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                   (state == S_DATA_HI) || (state == S_DATA_LO) ||
                   (state == S_WRITE) || (state == S_CSUM);

   // WRITE is the loader's own stall, so it neither counts nor clears.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         idle <= '0;
      end else if (!active || take) begin
         idle <= '0;
      end else if (state != S_WRITE) begin
         idle <= idle + 16'd1;
      end
   end

   assign timeout = active && !take && (state != S_WRITE) && (idle == TO_LAST);
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:    if (take && hdr) state_nx = S_LEN_HI;
         S_LEN_HI:  if (take) state_nx = S_LEN_LO;
         S_LEN_LO: begin
            if (take) begin
               if ({1'b0, len_full} > DEPTH_W) state_nx = S_ERROR;
               else if (len_full == 16'd0)     state_nx = S_CSUM;
               else                            state_nx = S_DATA_HI;
            end
         end
         S_DATA_HI: if (take) state_nx = S_DATA_LO;
         S_DATA_LO: if (take) state_nx = S_WRITE;
         S_WRITE:   state_nx = (count + 16'd1 == len) ? S_CSUM : S_DATA_HI;
         S_CSUM:    if (take) state_nx = (rx_data == sum) ? S_DONE : S_ERROR;
         S_DONE,
         S_ERROR:   if (take && hdr) state_nx = S_LEN_HI;
         default:   state_nx = S_IDLE;
      endcase
      if (timeout) state_nx = S_ERROR;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         count   <= '0;
         len     <= '0;
         sum     <= '0;
         hi      <= '0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         state <= state_nx;
         if (take) begin
            unique case (state)
               S_IDLE, S_DONE, S_ERROR: begin
                  if (hdr) begin
                     sum   <= '0;
                     count <= '0;
                  end
               end
               S_LEN_HI: begin
                  len[15:8] <= rx_data;
                  sum       <= sum + rx_data;
               end
               S_LEN_LO: begin
                  len[7:0] <= rx_data;
                  sum      <= sum + rx_data;
               end
               S_DATA_HI: begin
                  hi  <= rx_data;
                  sum <= sum + rx_data;
               end
               S_DATA_LO: begin
                  wr_data <= {hi, rx_data};
                  wr_addr <= BASE + count;
                  sum     <= sum + rx_data;
               end
               default: ;
            endcase
         end
         if (state == S_WRITE) count <= count + 16'd1;
      end
   end

   assign rx_ready = reset_n && (state != S_WRITE);
   assign wr_en    = state == S_WRITE;
   assign done     = state == S_DONE;
   assign err      = state == S_ERROR;
   assign cpu_hold = state != S_DONE;

endmodule
